// File: rtl/seq_multiplier_if.sv
// Launch/busy handshake bundle shared by the execute-stage multiplier and its sequencer.
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 launch;
  logic [1:0]           op;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     result;

  modport master (
    output launch, op, multiplicand, multiplier,
    input  busy, done, product, result
  );

  modport slave (
    input  launch, op, multiplicand, multiplier,
    output busy, done, product, result
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU): magnitudes are
// multiplied one bit per cycle, then a single fix cycle applies the sign.
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  seq_multiplier_if.slave    bus
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;
  logic                       w_busy;
  logic                       w_load;
  logic                       w_step;
  logic                       w_fix;
  logic                       w_last_step;

  logic [1:0]                 r_op;
  logic [WIDTH-1:0]           r_a_mag;
  logic [WIDTH-1:0]           r_b_mag;
  logic                       r_neg;
  logic [2*WIDTH-1:0]         r_acc;
  logic [CNT_W-1:0]           r_cnt;
  logic [2*WIDTH-1:0]         r_product;
  logic [WIDTH-1:0]           r_result;
  logic                       r_done;

  logic                       w_a_sgn;
  logic                       w_b_sgn;
  logic [WIDTH-1:0]           w_a_mag;
  logic [WIDTH-1:0]           w_b_mag;
  logic [WIDTH-1:0]           w_addend;
  logic [WIDTH:0]             w_sum;
  logic signed [2*WIDTH-1:0]  w_acc_signed;
  logic [2*WIDTH-1:0]         w_fixed;

  assign w_last_step = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A new launch always wins, even over an operation about to complete.
  always_comb begin
    w_next_state = r_state;
    if (bus.launch) begin
      w_next_state = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:  w_next_state = S_IDLE;
        S_RUN:   w_next_state = w_last_step ? S_FIX : S_RUN;
        S_FIX:   w_next_state = S_IDLE;
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy = 1'b0;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    case (r_state)
      S_RUN:   w_busy = 1'b1;
      S_FIX:   w_busy = 1'b1;
      default: w_busy = 1'b0;
    endcase
    w_load = bus.launch;
    w_step = (r_state == S_RUN) && !bus.launch;
    w_fix  = (r_state == S_FIX) && !bus.launch;
  end

  // Signedness per op: a is signed for MULH/MULHSU, b only for MULH.
  assign w_a_sgn  = ((bus.op == 2'b01) || (bus.op == 2'b10)) && bus.multiplicand[WIDTH-1];
  assign w_b_sgn  = (bus.op == 2'b01) && bus.multiplier[WIDTH-1];
  assign w_a_mag  = w_a_sgn ? -bus.multiplicand : bus.multiplicand;
  assign w_b_mag  = w_b_sgn ? -bus.multiplier   : bus.multiplier;

  assign w_addend     = r_b_mag[0] ? r_a_mag : '0;
  assign w_sum        = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_acc_signed = -$signed(r_acc);
  assign w_fixed      = r_neg ? w_acc_signed : r_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= 2'b00;
      r_a_mag   <= '0;
      r_b_mag   <= '0;
      r_neg     <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_op    <= bus.op;
        r_a_mag <= w_a_mag;
        r_b_mag <= w_b_mag;
        r_neg   <= w_a_sgn ^ w_b_sgn;
        r_acc   <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        // Carry-out of the upper-half add re-enters at the MSB as the accumulator shifts.
        r_acc   <= {w_sum, r_acc[WIDTH-1:1]};
        r_b_mag <= r_b_mag >> 1;
        r_cnt   <= r_cnt + CNT_W'(1);
      end else if (w_fix) begin
        r_product <= w_fixed;
        r_result  <= (r_op == 2'b00) ? w_fixed[WIDTH-1:0] : w_fixed[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.busy    = w_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;
  assign bus.result  = r_result;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier at WIDTH=4 and WIDTH=32.
`timescale 1ns/1ps
module tb_seq_multiplier;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  seq_multiplier_if #(.WIDTH(4))  if4 ();
  seq_multiplier_if #(.WIDTH(32)) if32 ();

  seq_multiplier #(.WIDTH(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if4)
  );

  seq_multiplier #(.WIDTH(32)) u_dut32 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w32, input logic l, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w32) begin
      if32.launch = l; if32.op = op; if32.multiplicand = a; if32.multiplier = b;
    end else begin
      if4.launch = l; if4.op = op; if4.multiplicand = a[3:0]; if4.multiplier = b[3:0];
    end
  endtask

  function automatic logic get_busy(input bit w32);
    return w32 ? if32.busy : if4.busy;
  endfunction

  function automatic logic get_done(input bit w32);
    return w32 ? if32.done : if4.done;
  endfunction

  function automatic logic [63:0] get_prod(input bit w32);
    return w32 ? if32.product : {56'b0, if4.product};
  endfunction

  function automatic logic [31:0] get_res(input bit w32);
    return w32 ? if32.result : {28'b0, if4.result};
  endfunction

  function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] ea;
    logic signed [63:0] eb;
    ea = ((op == 2'b01) || (op == 2'b10)) ? {{32{a[31]}}, a} : {32'b0, a};
    eb = (op == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Launch one op (caller sits just after a rising edge), then follow it to its done pulse.
  task automatic run_op(input bit w32, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_p,
                        input logic [31:0] exp_r, input bit chk_p, input string tag);
    int nb;
    bit seen;
    bit overlap;
    nb = 0; seen = 0; overlap = 0;
    drive(w32, 1'b1, op, a, b);
    @(posedge clk); #1;
    drive(w32, 1'b0, op, a, b);
    for (int i = 0; i < 60; i++) begin
      if (get_done(w32) && get_busy(w32)) overlap = 1;
      if (get_done(w32)) begin
        seen = 1;
        break;
      end
      if (get_busy(w32)) nb++;
      @(posedge clk); #1;
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    chk({tag, " busy_cycles"}, 64'(nb), w32 ? 64'd33 : 64'd5);
    chk({tag, " done_busy_overlap"}, 64'(overlap), 64'd0);
    if (chk_p) chk({tag, " product"}, get_prod(w32), exp_p);
    chk({tag, " result"}, 64'(get_res(w32)), 64'(exp_r));
    @(posedge clk); #1;
    chk({tag, " done_width"}, 64'(get_done(w32)), 64'd0);
  endtask

  initial begin
    bit seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rp;
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    chk("reset busy",    64'(if4.busy),    64'd0);
    chk("reset done",    64'(if4.done),    64'd0);
    chk("reset product", 64'(if4.product), 64'd0);
    chk("reset result",  64'(if4.result),  64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    run_op(1'b0, 2'b00, 32'hD, 32'h5, 64'h0,  32'h1, 1'b0, "w4 D*5 mul");
    run_op(1'b0, 2'b01, 32'hD, 32'h5, 64'hF1, 32'hF, 1'b1, "w4 D*5 mulh");
    run_op(1'b0, 2'b10, 32'hD, 32'h5, 64'hF1, 32'hF, 1'b1, "w4 D*5 mulhsu");
    run_op(1'b0, 2'b11, 32'hD, 32'h5, 64'h41, 32'h4, 1'b1, "w4 D*5 mulhu");

    run_op(1'b0, 2'b01, 32'h8, 32'h8, 64'h40, 32'h4, 1'b1, "w4 8*8 mulh");
    run_op(1'b0, 2'b10, 32'h8, 32'h8, 64'hC0, 32'hC, 1'b1, "w4 8*8 mulhsu");
    run_op(1'b0, 2'b00, 32'h8, 32'h8, 64'h0,  32'h0, 1'b0, "w4 8*8 mul");
    run_op(1'b0, 2'b11, 32'h8, 32'h8, 64'h40, 32'h4, 1'b1, "w4 8*8 mulhu");

    // Abort: first op launched, relaunched two cycles later; only the second completes.
    drive(1'b0, 1'b1, 2'b11, 32'h7, 32'h3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b11, 32'h7, 32'h3);
    chk("abort hold product", 64'(if4.product), 64'h40);
    chk("abort hold result",  64'(if4.result),  64'h4);
    chk("abort no done",      64'(if4.done),    64'd0);
    @(posedge clk); #1;
    run_op(1'b0, 2'b00, 32'h2, 32'h3, 64'h06, 32'h6, 1'b1, "w4 abort relaunch");

    // Asynchronous reset in the middle of RUN.
    drive(1'b0, 1'b1, 2'b11, 32'hD, 32'h5);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 2'b11, 32'hD, 32'h5);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("midrun reset busy",    64'(if4.busy),    64'd0);
    chk("midrun reset done",    64'(if4.done),    64'd0);
    chk("midrun reset product", 64'(if4.product), 64'd0);
    chk("midrun reset result",  64'(if4.result),  64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (10) begin
      if (if4.done || if4.busy) seen = 1;
      @(posedge clk); #1;
    end
    chk("midrun reset no done", 64'(seen), 64'd0);

    run_op(1'b1, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 32'hFFFFFFFE,
           1'b1, "w32 ff*ff mulhu");
    run_op(1'b1, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h1, 32'h0, 1'b1, "w32 ff*ff mulh");
    run_op(1'b1, 2'b01, 32'h0, 32'h80000000, 64'h0, 32'h0, 1'b1, "w32 zero mulh");
    run_op(1'b1, 2'b11, 32'h0, 32'h12345678, 64'h0, 32'h0, 1'b1, "w32 zero mulhu");

    for (int n = 0; n < 1500; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      if (n % 16 == 0) ra = 32'h80000000;
      if (n % 16 == 1) rb = 32'h80000000;
      if (n % 16 == 2) ra = 32'h0;
      rp = ref_prod(rop, ra, rb);
      run_op(1'b1, rop, ra, rb, rp, (rop == 2'b00) ? rp[31:0] : rp[63:32],
             rop != 2'b00, "w32 random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
